pwm_ctrl: RTL
=============

# pwm_ctrl

Register-mapped controller that sits directly upstream of the `pwm` generator and drives its `en`, `period`, `duty_cycle` and `polarity` inputs. It accepts single-cycle register writes and reads from the bus bridge and holds them in shadow registers. It commits the shadow values to the live outputs only at PWM period boundaries, so the waveform never glitches. An optional ramp engine slews the live duty toward the target by a programmed step once per period, giving a soft start.

## Interface
- `COUNTER_WIDTH`, default 16: width of period, duty, step and data buses; must match the downstream `pwm`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe, one cycle per write.
- `rd_en`  in  1  read strobe, one cycle per read.
- `addr`  in  2  register select: 0 CTRL, 1 PERIOD, 2 DUTY (target), 3 STEP.
- `wdata`  in  COUNTER_WIDTH  write data.
- `rdata`  out  COUNTER_WIDTH  read data, registered.
- `rd_valid`  out  1  one-cycle pulse qualifying `rdata`.
- `en`  out  1  live enable to `pwm`.
- `period`  out  COUNTER_WIDTH  live period to `pwm`.
- `duty_cycle`  out  COUNTER_WIDTH  live duty to `pwm`.
- `polarity`  out  1  live polarity to `pwm`.
- `period_tick`  out  1  one-cycle pulse on the last clock of each PWM period.
- `ramp_busy`  out  1  high while live duty differs from the target.

## Operation
- Reset value of every output and register is 0, including shadows, the mirror counter and ramp state.
- CTRL register: bit0 = en, bit1 = polarity, other bits ignored on write. A CTRL read returns bit2 = `ramp_busy` and all other unused bits as 0.
- A write updates the addressed shadow register on the same edge. A write with both `wr_en` and `rd_en` high performs both; the read returns the pre-write value.
- Mirror counter `cnt` tracks the downstream `pwm` counter:
  - When live `en`=0, `cnt`=0.
  - When live `en`=1, `cnt` counts 0..`period` and wraps to 0. Each PWM period is therefore `period`+1 clocks.
- `period_tick` = live `en` AND (`cnt` == live `period`). With `period`=0, it pulses every cycle.
- Behaviour on `period_tick`:
  - Live `period` and `polarity` load from their shadows.
  - Live `duty_cycle` loads from the target, or takes one ramp step when the ramp engine is compiled in.
  - A write in the same cycle as a tick lands in the shadow only; the tick commits the old shadow value, and the new value commits on the next tick.
- While live `en`=0, live `period` and `polarity` follow their shadows on the same edge as the write.
- `en` itself is never deferred:
  - A CTRL write takes effect on the live `en` at the write edge.
  - Disabling also clears `cnt` on that edge.
- Ramp FSM (macro enabled), states IDLE, UP, DOWN, evaluated only on `period_tick`:
  - IDLE: if duty < target, go to UP; if duty > target, go to DOWN.
  - UP: duty = min(duty+step, target). The sum is computed in COUNTER_WIDTH+1 bits, so there is no wrap-around.
  - DOWN: duty = max(duty−step, target), with no underflow below target.
  - Return to IDLE when duty == target.
  - STEP=0 means jump to the target on the next tick.
  - A target change mid-ramp re-evaluates direction at the next tick.
  - While live `en`=0, live duty is held at 0 and the FSM is in IDLE. Every enable therefore soft-starts from 0.
- `ramp_busy` = (live `duty_cycle` != target), registered.

## Timing
- Write at edge N: shadow visible after N. While disabled, the live outputs are also visible after N.
- While enabled, live `period`, `polarity` and `duty_cycle` change only on the edge at which `period_tick` is high.
- The downstream `pwm` sees new values starting with `cnt`=0 of the next period.
- Read: `rd_en` at edge N gives `rdata` and `rd_valid` valid after N for one cycle. `rdata` holds its value until the next read.
- Reset asserted mid-operation: all outputs go to 0 asynchronously. After release, the block waits for register writes.

## Configuration
- `PWM_CTRL_RAMP_EN` defined: ramp FSM and STEP register are present, with the soft start described above.
- `PWM_CTRL_RAMP_EN` not defined:
  - STEP writes are ignored and STEP reads return 0.
  - Live duty loads the target directly at each tick, or immediately while disabled.
  - `ramp_busy` is high only between a target write and the next tick.

## Test plan
- Reset, then read all 4 addresses -> every `rdata`=0, `rd_valid` high for 1 cycle per read, all outputs 0.
- PERIOD=9, DUTY=4, STEP=0, CTRL=1 -> `period_tick` every 10 clocks; `duty_cycle`=4 after the first tick.
- Enabled with PERIOD=9; write PERIOD=3 when `cnt`=5 -> `period` stays 9 until the tick at `cnt`=9, then the tick period becomes 4 clocks.
- Ramp build, PERIOD=4, DUTY=10, STEP=3, enable -> `duty_cycle` 0,3,6,9,10 on successive ticks; `ramp_busy` drops after the value 10 is reached. Then write DUTY=2 -> 7,4,2.
- PERIOD=0xFFFF, DUTY=0xFFFF, STEP=0xFFF0 -> `duty_cycle` saturates at 0xFFFF after 2 ticks, with no wrap.
- Write at the exact tick cycle, and separately CTRL=0 mid-period -> the first commits on the following tick; the second drops `en`, clears `cnt` and sets `duty_cycle` to 0 on the write edge.

Source files
------------

// File: rtl/pwm_ctrl.sv
// pwm_ctrl -- register front end for the downstream pwm generator.
//
// Bus writes land in shadow registers immediately. The live outputs that feed
// the pwm (period, polarity, duty_cycle) pick up the shadows only on the last
// clock of a PWM period, so a waveform period is never cut short or stretched
// by a mid-period update. The live enable is the exception: it follows CTRL
// writes on the write edge, and disabling also restarts the mirror counter.
//
// Build option: define PWM_CTRL_RAMP_EN to include the STEP register and the
// ramp engine. With the ramp engine, the live duty moves toward the target by
// at most STEP per period, so every enable soft-starts from 0. Without it,
// STEP reads as 0, and the live duty loads the target directly.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   wr_en        one-cycle write strobe
//   rd_en        one-cycle read strobe
//   addr         0 CTRL, 1 PERIOD, 2 DUTY (target), 3 STEP
//   wdata        write data
//   rdata        registered read data, held until the next read
//   rd_valid     one-cycle pulse qualifying rdata
//   en           live enable to pwm
//   period       live period to pwm
//   duty_cycle   live duty to pwm
//   polarity     live polarity to pwm
//   period_tick  high on the last clock of each PWM period
//   ramp_busy    registered (live duty != target)
//
// CTRL layout: bit0 en, bit1 polarity, bit2 ramp_busy (read only).
// COUNTER_WIDTH must be at least 3 so the CTRL read bits fit.

module pwm_ctrl #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [1:0]               addr,
  input  logic [COUNTER_WIDTH-1:0] wdata,
  output logic [COUNTER_WIDTH-1:0] rdata,
  output logic                     rd_valid,
  output logic                     en,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] duty_cycle,
  output logic                     polarity,
  output logic                     period_tick,
  output logic                     ramp_busy
);

  localparam int W = COUNTER_WIDTH;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STEP   = 2'd3;

  // Bus-visible state
  logic         en_reg, en_next;
  logic         pol_shadow_reg, pol_shadow_next;
  logic [W-1:0] period_shadow_reg, period_shadow_next;
  logic [W-1:0] target_reg, target_next;

  // Live outputs and mirror counter
  logic [W-1:0] period_reg, period_next;
  logic         pol_reg, pol_next;
  logic [W-1:0] duty_reg, duty_next;
  logic [W-1:0] cnt_reg, cnt_next;
  logic         busy_reg, busy_next;

  // Read port
  logic [W-1:0] rdata_reg, rdata_next;
  logic         rd_valid_reg;
  logic [W-1:0] rd_ctrl;

  logic         tick;

  assign tick = en_reg && (cnt_reg == period_reg);

`ifdef PWM_CTRL_RAMP_EN
  typedef enum logic [1:0] {
    RAMP_IDLE,
    RAMP_UP,
    RAMP_DOWN
  } ramp_state_t;

  ramp_state_t  state_reg, state_next;
  ramp_state_t  ramp_dir;
  logic [W-1:0] step_reg, step_next;
  logic [W:0]   ramp_sum;
  logic [W-1:0] ramp_gap;
  logic [W-1:0] ramp_value;
  logic         below, above;

  // Direction for the coming tick. The comparison is redone every tick, so a
  // target that moves past the live duty mid-ramp flips the direction.
  always_comb begin
    below    = duty_reg < target_reg;
    above    = duty_reg > target_reg;
    ramp_dir = RAMP_IDLE;
    unique case (state_reg)
      RAMP_UP:   ramp_dir = below ? RAMP_UP   : (above ? RAMP_DOWN : RAMP_IDLE);
      RAMP_DOWN: ramp_dir = above ? RAMP_DOWN : (below ? RAMP_UP   : RAMP_IDLE);
      default:   ramp_dir = below ? RAMP_UP   : (above ? RAMP_DOWN : RAMP_IDLE);
    endcase
  end

  // One step toward the target, clamped at the target. The sum has a carry
  // bit so a large step near full scale cannot wrap. STEP=0 jumps directly.
  always_comb begin
    ramp_sum   = {1'b0, duty_reg} + {1'b0, step_reg};
    ramp_gap   = duty_reg - target_reg;
    ramp_value = duty_reg;
    case (ramp_dir)
      RAMP_UP: begin
        if (step_reg == '0 || ramp_sum >= {1'b0, target_reg})
          ramp_value = target_reg;
        else
          ramp_value = ramp_sum[W-1:0];
      end
      RAMP_DOWN: begin
        if (step_reg == '0 || ramp_gap <= step_reg)
          ramp_value = target_reg;
        else
          ramp_value = duty_reg - step_reg;
      end
      default: ramp_value = duty_reg;
    endcase
  end
`endif

  // Shadow register updates from the bus
  always_comb begin
    en_next            = en_reg;
    pol_shadow_next    = pol_shadow_reg;
    period_shadow_next = period_shadow_reg;
    target_next        = target_reg;
`ifdef PWM_CTRL_RAMP_EN
    step_next          = step_reg;
`endif
    if (wr_en) begin
      case (addr)
        ADDR_CTRL: begin
          en_next         = wdata[0];
          pol_shadow_next = wdata[1];
        end
        ADDR_PERIOD: period_shadow_next = wdata;
        ADDR_DUTY:   target_next        = wdata;
        ADDR_STEP: begin
`ifdef PWM_CTRL_RAMP_EN
          step_next = wdata;
`endif
        end
        default: ;
      endcase
    end
  end

  // Live outputs, mirror counter and ramp state
  always_comb begin
    period_next = period_reg;
    pol_next    = pol_reg;
    duty_next   = duty_reg;
    cnt_next    = cnt_reg;
`ifdef PWM_CTRL_RAMP_EN
    state_next  = state_reg;
`endif
    if (!en_reg) begin
      // Nothing is running downstream, so there is no period to protect:
      // follow the shadows including any write on this same edge.
      period_next = period_shadow_next;
      pol_next    = pol_shadow_next;
      cnt_next    = '0;
`ifdef PWM_CTRL_RAMP_EN
      duty_next   = '0;
      state_next  = RAMP_IDLE;
`else
      duty_next   = target_next;
`endif
    end else begin
      cnt_next = tick ? '0 : cnt_reg + 1'b1;
      if (tick) begin
        // Commit the pre-write shadows; a write on this edge waits a period.
        period_next = period_shadow_reg;
        pol_next    = pol_shadow_reg;
`ifdef PWM_CTRL_RAMP_EN
        duty_next   = ramp_value;
        state_next  = (ramp_value == target_reg) ? RAMP_IDLE : ramp_dir;
`else
        duty_next   = target_reg;
`endif
      end
      // Disable acts at once: counter restarts and the duty drops to 0.
      if (!en_next) begin
        cnt_next   = '0;
        duty_next  = '0;
`ifdef PWM_CTRL_RAMP_EN
        state_next = RAMP_IDLE;
`endif
      end
    end
    busy_next = (duty_next != target_next);
  end

  // Read mux sees the pre-write register values
  always_comb begin
    rd_ctrl    = '0;
    rd_ctrl[0] = en_reg;
    rd_ctrl[1] = pol_shadow_reg;
    rd_ctrl[2] = busy_reg;
    rdata_next = rdata_reg;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:   rdata_next = rd_ctrl;
        ADDR_PERIOD: rdata_next = period_shadow_reg;
        ADDR_DUTY:   rdata_next = target_reg;
`ifdef PWM_CTRL_RAMP_EN
        ADDR_STEP:   rdata_next = step_reg;
`else
        ADDR_STEP:   rdata_next = '0;
`endif
        default:     rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg            <= 1'b0;
      pol_shadow_reg    <= 1'b0;
      period_shadow_reg <= '0;
      target_reg        <= '0;
      period_reg        <= '0;
      pol_reg           <= 1'b0;
      duty_reg          <= '0;
      cnt_reg           <= '0;
      busy_reg          <= 1'b0;
      rdata_reg         <= '0;
      rd_valid_reg      <= 1'b0;
`ifdef PWM_CTRL_RAMP_EN
      step_reg          <= '0;
      state_reg         <= RAMP_IDLE;
`endif
    end else begin
      en_reg            <= en_next;
      pol_shadow_reg    <= pol_shadow_next;
      period_shadow_reg <= period_shadow_next;
      target_reg        <= target_next;
      period_reg        <= period_next;
      pol_reg           <= pol_next;
      duty_reg          <= duty_next;
      cnt_reg           <= cnt_next;
      busy_reg          <= busy_next;
      rdata_reg         <= rdata_next;
      rd_valid_reg      <= rd_en;
`ifdef PWM_CTRL_RAMP_EN
      step_reg          <= step_next;
      state_reg         <= state_next;
`endif
    end
  end

  assign en          = en_reg;
  assign period      = period_reg;
  assign duty_cycle  = duty_reg;
  assign polarity    = pol_reg;
  assign period_tick = tick;
  assign ramp_busy   = busy_reg;
  assign rdata       = rdata_reg;
  assign rd_valid    = rd_valid_reg;

endmodule
